mul_share_arb: RTL and testbench

- Round-robin arbiter and scheduler that shares one pipelined `mul` instance between two requesters.
- Accepts operand pairs via valid/ready, drives the multiplier operand inputs, and tracks each issued operation with a requester tag through the pipeline.
- Returns each product to the requester that issued it as a one-cycle response pulse.
- Sits between the two client blocks and the existing multi-cycle multiplier; the multiplier itself is external.

---
 rtl/mul_share_arb.sv | 175 +++++++++++++++++
 tb/tb_mul_share_arb.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_share_arb.sv
// mul_share_arb
// Round-robin arbiter/scheduler sharing one external pipelined multiplier
// between two requesters. Each accepted operand pair is registered onto
// mul_a/mul_b and tagged with its requester id. The tag travels down a
// LAT+1 stage shift pipeline so that the product is steered back to the
// requester that issued it.
//
// Ports:
//   clk, rst_n              clock (rising edge), async active-low reset
//   reqN_valid/a/b/ready    operand handshake for requester N (N = 0, 1)
//   mul_a, mul_b            registered operands to the shared multiplier
//   mul_p                   product from the shared multiplier (LAT edges later)
//   rspN_valid, rspN_p      one-cycle response pulse and held product
//   idle                    nothing in flight and no request pending
module mul_share_arb #(
    parameter int W   = 4,
    parameter int LAT = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    input  logic [W-1:0]     req0_a,
    input  logic [W-1:0]     req0_b,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [W-1:0]     req1_a,
    input  logic [W-1:0]     req1_b,
    output logic             req1_ready,
    output logic [W-1:0]     mul_a,
    output logic [W-1:0]     mul_b,
    input  logic [2*W-1:0]   mul_p,
    output logic             rsp0_valid,
    output logic [2*W-1:0]   rsp0_p,
    output logic             rsp1_valid,
    output logic [2*W-1:0]   rsp1_p,
    output logic             idle
);

    typedef enum logic [0:0] {
        ST_EMPTY = 1'b0,
        ST_BUSY  = 1'b1
    } state_t;

    state_t         state_r;
    state_t         state_nxt_s;
    logic           ptr_r;
    logic           gnt0_s;
    logic           gnt1_s;
    logic           xfer_s;
    logic [LAT:0]   tag_vld_r;
    logic [LAT:0]   tag_id_r;
    logic           out_vld_s;
    logic           out_id_s;

    // Grant selection: a lone requester always wins, a tie goes to the pointer.
    always_comb begin
        gnt0_s = 1'b0;
        gnt1_s = 1'b0;
        if (req0_valid && req1_valid) begin
            gnt0_s = ~ptr_r;
            gnt1_s = ptr_r;
        end else if (req0_valid) begin
            gnt0_s = 1'b1;
        end else if (req1_valid) begin
            gnt1_s = 1'b1;
        end else begin
            gnt0_s = 1'b0;
            gnt1_s = 1'b0;
        end
    end

    assign req0_ready = gnt0_s;
    assign req1_ready = gnt1_s;
    assign xfer_s     = gnt0_s | gnt1_s;

    // The tag leaving the last stage lines up with the product on mul_p.
    assign out_vld_s  = tag_vld_r[LAT];
    assign out_id_s   = tag_id_r[LAT];

    // Priority pointer toggles only when an operand pair is actually taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_r <= 1'b0;
        end else if (xfer_s) begin
            ptr_r <= ~ptr_r;
        end else begin
            ptr_r <= ptr_r;
        end
    end

    // Operand registers: load the granted pair, otherwise hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mul_a <= {W{1'b0}};
            mul_b <= {W{1'b0}};
        end else if (xfer_s) begin
            mul_a <= gnt1_s ? req1_a : req0_a;
            mul_b <= gnt1_s ? req1_b : req0_b;
        end else begin
            mul_a <= mul_a;
            mul_b <= mul_b;
        end
    end

    // Tag shift pipeline; stage 0 captures the issue of this edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_vld_r <= {(LAT+1){1'b0}};
            tag_id_r  <= {(LAT+1){1'b0}};
        end else begin
            tag_vld_r <= {tag_vld_r[LAT-1:0], xfer_s};
            tag_id_r  <= {tag_id_r[LAT-1:0], gnt1_s};
        end
    end

    // Response registers: pulse valid, hold product between responses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
            rsp0_p     <= {(2*W){1'b0}};
            rsp1_p     <= {(2*W){1'b0}};
        end else begin
            rsp0_valid <= out_vld_s & ~out_id_s;
            rsp1_valid <= out_vld_s & out_id_s;
            if (out_vld_s && !out_id_s) begin
                rsp0_p <= mul_p;
            end else begin
                rsp0_p <= rsp0_p;
            end
            if (out_vld_s && out_id_s) begin
                rsp1_p <= mul_p;
            end else begin
                rsp1_p <= rsp1_p;
            end
        end
    end

    // Occupancy state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_EMPTY;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next occupancy: busy while a new issue arrives or an older tag survives
    // the shift (anything in stages 0..LAT-1 moves on rather than leaving).
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_EMPTY: begin
                if (xfer_s) begin
                    state_nxt_s = ST_BUSY;
                end else begin
                    state_nxt_s = ST_EMPTY;
                end
            end
            ST_BUSY: begin
                if (xfer_s || (|tag_vld_r[LAT-1:0])) begin
                    state_nxt_s = ST_BUSY;
                end else begin
                    state_nxt_s = ST_EMPTY;
                end
            end
            default: begin
                state_nxt_s = ST_EMPTY;
            end
        endcase
    end

    assign idle = (state_r == ST_EMPTY) & ~req0_valid & ~req1_valid;

endmodule

// File: tb/tb_mul_share_arb.sv
// tb_mul_share_arb
// Directed bench for mul_share_arb (W=4, LAT=2) with a behavioural
// LAT-stage multiplier model standing in for the external multiplier.
module tb_mul_share_arb;

    localparam int W   = 4;
    localparam int LAT = 2;

    logic             clk;
    logic             rst_n;
    logic             req0_valid;
    logic [W-1:0]     req0_a;
    logic [W-1:0]     req0_b;
    logic             req0_ready;
    logic             req1_valid;
    logic [W-1:0]     req1_a;
    logic [W-1:0]     req1_b;
    logic             req1_ready;
    logic [W-1:0]     mul_a;
    logic [W-1:0]     mul_b;
    logic [2*W-1:0]   mul_p;
    logic             rsp0_valid;
    logic [2*W-1:0]   rsp0_p;
    logic             rsp1_valid;
    logic [2*W-1:0]   rsp1_p;
    logic             idle;

    int total;
    int bad;

    mul_share_arb #(.W(W), .LAT(LAT)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_ready (req1_ready),
        .mul_a      (mul_a),
        .mul_b      (mul_b),
        .mul_p      (mul_p),
        .rsp0_valid (rsp0_valid),
        .rsp0_p     (rsp0_p),
        .rsp1_valid (rsp1_valid),
        .rsp1_p     (rsp1_p),
        .idle       (idle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural multiplier: product of operands seen at edge k appears in cycle k+LAT.
    logic [2*W-1:0] pipe [LAT];
    logic [2*W-1:0] ext_a;
    logic [2*W-1:0] ext_b;
    assign ext_a = {{W{1'b0}}, mul_a};
    assign ext_b = {{W{1'b0}}, mul_b};
    assign mul_p = pipe[LAT-1];

    always_ff @(posedge clk) begin
        pipe[0] <= ext_a * ext_b;
        for (int i = 1; i < LAT; i++) begin
            pipe[i] <= pipe[i-1];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [7:0] exp3 [4];
    logic       e0;
    logic       e1;

    initial begin
        total = 0;
        bad   = 0;
        exp3[0] = 8'd2; exp3[1] = 8'd6; exp3[2] = 8'd12; exp3[3] = 8'd20;
        rst_n = 1'b0;
        req0_valid = 1'b0; req0_a = 4'd0; req0_b = 4'd0;
        req1_valid = 1'b0; req1_a = 4'd0; req1_b = 4'd0;
        #1;
        chk("rst_ready0", 32'(req0_ready), 32'd0);
        chk("rst_ready1", 32'(req1_ready), 32'd0);
        chk("rst_mul_a",  32'(mul_a), 32'd0);
        chk("rst_rsp0",   32'(rsp0_valid), 32'd0);
        chk("rst_rsp1_p", 32'(rsp1_p), 32'd0);
        chk("rst_idle",   32'(idle), 32'd1);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // Test 1: single req0 13*11
        req0_valid = 1'b1; req0_a = 4'd13; req0_b = 4'd11;
        #1;
        chk("t1_ready0", 32'(req0_ready), 32'd1);
        chk("t1_ready1", 32'(req1_ready), 32'd0);
        chk("t1_idle_req", 32'(idle), 32'd0);
        step();
        req0_valid = 1'b0;
        chk("t1_mul_a", 32'(mul_a), 32'd13);
        chk("t1_mul_b", 32'(mul_b), 32'd11);
        step();
        chk("t1_c1_rsp0", 32'(rsp0_valid), 32'd0);
        step();
        chk("t1_c2_rsp0", 32'(rsp0_valid), 32'd0);
        chk("t1_c2_idle", 32'(idle), 32'd0);
        step();
        chk("t1_c3_rsp0", 32'(rsp0_valid), 32'd1);
        chk("t1_c3_p",    32'(rsp0_p), 32'd143);
        chk("t1_c3_rsp1", 32'(rsp1_valid), 32'd0);
        step();
        chk("t1_c4_rsp0", 32'(rsp0_valid), 32'd0);
        chk("t1_c4_hold", 32'(rsp0_p), 32'd143);
        chk("t1_c4_idle", 32'(idle), 32'd1);

        // Test 5: zero operand still responds (pointer returns to 0)
        req0_valid = 1'b1; req0_a = 4'd0; req0_b = 4'd9;
        #1;
        chk("t5_ready0", 32'(req0_ready), 32'd1);
        step();
        req0_valid = 1'b0;
        step();
        step();
        chk("t5_c2_rsp0", 32'(rsp0_valid), 32'd0);
        step();
        chk("t5_c3_rsp0", 32'(rsp0_valid), 32'd1);
        chk("t5_c3_p",    32'(rsp0_p), 32'd0);
        step();
        chk("t5_c4_rsp0", 32'(rsp0_valid), 32'd0);
        chk("t5_c4_idle", 32'(idle), 32'd1);

        // Test 2: both valid for 4 edges, alternating grants 0,1,0,1
        req0_valid = 1'b1; req0_a = 4'd15; req0_b = 4'd15;
        req1_valid = 1'b1; req1_a = 4'd3;  req1_b = 4'd5;
        for (int c = 0; c < 7; c++) begin
            #1;
            if (c < 4) begin
                chk("t2_ready0", 32'(req0_ready), ((c % 2) == 0) ? 32'd1 : 32'd0);
                chk("t2_ready1", 32'(req1_ready), ((c % 2) == 1) ? 32'd1 : 32'd0);
            end
            step();
            if (c == 3) begin
                req0_valid = 1'b0;
                req1_valid = 1'b0;
            end
            if (c == 0) chk("t2_mul_a0", 32'(mul_a), 32'd15);
            if (c == 1) chk("t2_mul_a1", 32'(mul_a), 32'd3);
            e0 = (c == 3) || (c == 5);
            e1 = (c == 4) || (c == 6);
            chk("t2_rsp0_v", 32'(rsp0_valid), 32'(e0));
            chk("t2_rsp1_v", 32'(rsp1_valid), 32'(e1));
            if (e0) chk("t2_rsp0_p", 32'(rsp0_p), 32'd225);
            if (e1) chk("t2_rsp1_p", 32'(rsp1_p), 32'd15);
        end

        // Test 6: req1 waits while req0 holds the pointer
        req0_valid = 1'b1; req0_a = 4'd2; req0_b = 4'd3;
        req1_valid = 1'b1; req1_a = 4'd7; req1_b = 4'd7;
        #1;
        chk("t6_ready0", 32'(req0_ready), 32'd1);
        chk("t6_ready1_wait", 32'(req1_ready), 32'd0);
        step();
        req0_valid = 1'b0;
        #1;
        chk("t6_ready1_next", 32'(req1_ready), 32'd1);
        chk("t6_mul_a0", 32'(mul_a), 32'd2);
        step();
        req1_valid = 1'b0;
        chk("t6_mul_a1", 32'(mul_a), 32'd7);
        chk("t6_mul_b1", 32'(mul_b), 32'd7);
        step();
        step();
        chk("t6_c3_rsp0", 32'(rsp0_valid), 32'd1);
        chk("t6_c3_p0",   32'(rsp0_p), 32'd6);
        step();
        chk("t6_c4_rsp1", 32'(rsp1_valid), 32'd1);
        chk("t6_c4_p1",   32'(rsp1_p), 32'd49);
        step();
        chk("t6_c5_rsp1", 32'(rsp1_valid), 32'd0);

        // Test 3: req1 alone, 4 back-to-back pairs
        for (int c = 0; c < 7; c++) begin
            if (c < 4) begin
                req1_valid = 1'b1;
                req1_a = 4'(c + 1);
                req1_b = 4'(c + 2);
                #1;
                chk("t3_ready1", 32'(req1_ready), 32'd1);
            end else begin
                req1_valid = 1'b0;
            end
            step();
            if (c >= 3) begin
                chk("t3_rsp1_v", 32'(rsp1_valid), 32'd1);
                chk("t3_rsp1_p", 32'(rsp1_p), 32'(exp3[c-3]));
            end else begin
                chk("t3_rsp1_v", 32'(rsp1_valid), 32'd0);
            end
        end
        req1_valid = 1'b0;

        // Test 4: reset with operations in flight, pointer left at 1
        req0_valid = 1'b1; req0_a = 4'd3; req0_b = 4'd3;
        step();
        req0_valid = 1'b0;
        req1_valid = 1'b1; req1_a = 4'd2; req1_b = 4'd2;
        step();
        req1_valid = 1'b0;
        req0_valid = 1'b1; req0_a = 4'd1; req0_b = 4'd1;
        step();
        req0_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("t4_mul_a",   32'(mul_a), 32'd0);
        chk("t4_mul_b",   32'(mul_b), 32'd0);
        chk("t4_rsp0_p",  32'(rsp0_p), 32'd0);
        chk("t4_rsp1_p",  32'(rsp1_p), 32'd0);
        chk("t4_rsp0_v",  32'(rsp0_valid), 32'd0);
        chk("t4_idle",    32'(idle), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            step();
            chk("t4_no_rsp0", 32'(rsp0_valid), 32'd0);
            chk("t4_no_rsp1", 32'(rsp1_valid), 32'd0);
        end
        req0_valid = 1'b1; req0_a = 4'd1; req0_b = 4'd2;
        req1_valid = 1'b1; req1_a = 4'd3; req1_b = 4'd4;
        #1;
        chk("t4_ptr_ready0", 32'(req0_ready), 32'd1);
        chk("t4_ptr_ready1", 32'(req1_ready), 32'd0);
        step();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
